decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 57 +++++
 rtl/decode_ctrl.sv | 89 ++++++++
 rtl/decode_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes and the control bundle layout.
// Used by decode, execute and hazard logic so field positions never drift between stages.
package decode_stage_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } aluop_e;

  // Field order is the out_ctrl bit order, branch in bit 7 down to illegal in bit 0.
  typedef struct packed {
    logic branch;
    logic jump;
    logic memread;
    logic memtoreg;
    logic memwrite;
    logic alusrc;
    logic regwrite;
    logic illegal;
  } ctrl_t;

  // instr[30] picks SUB only for register-register ops, SRA for both forms.
  function automatic aluop_e alu_from_f3(input logic [2:0] f3, input logic alt, input logic is_op);
    aluop_e op;
    case (f3)
      3'd0:    op = (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational RV32I decode: control bits, ALU op, sign-extended immediate and source-register usage.
// Purely combinational, no latency and no flow control.
module decode_ctrl #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [7:0]      ctrl,
  output logic [3:0]      aluop,
  output logic [XLEN-1:0] imme,
  output logic            rs1_used,
  output logic            rs2_used
);
  import decode_stage_pkg::*;

  logic [6:0] opc;
  ctrl_t      c;
  aluop_e     op;

  assign opc  = instr[6:0];
  assign ctrl = c;
  assign aluop = op;

  always_comb begin
    c        = '0;
    op       = ALU_ADD;
    imme     = '0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opc)
      OPC_OP_IMM: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        op         = alu_from_f3(instr[14:12], instr[30], 1'b0);
        imme       = XLEN'(signed'(instr[31:20]));
      end
      OPC_OP: begin
        c.regwrite = 1'b1;
        op         = alu_from_f3(instr[14:12], instr[30], 1'b1);
        rs2_used   = 1'b1;
      end
      OPC_BRANCH: begin
        c.branch = 1'b1;
        op       = ALU_SUB;
        imme     = XLEN'(signed'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        rs2_used = 1'b1;
      end
      OPC_JAL: begin
        c.jump     = 1'b1;
        c.regwrite = 1'b1;
        imme       = XLEN'(signed'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        rs1_used   = 1'b0;
      end
      OPC_JALR: begin
        c.jump     = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        imme       = XLEN'(signed'(instr[31:20]));
      end
      OPC_LOAD: begin
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        imme       = XLEN'(signed'(instr[31:20]));
      end
      OPC_STORE: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        imme       = XLEN'(signed'({instr[31:25], instr[11:7]}));
        rs2_used   = 1'b1;
      end
      OPC_LUI: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        op         = ALU_PASSB;
        imme       = XLEN'(signed'({instr[31:12], 12'b0}));
        rs1_used   = 1'b0;
      end
      OPC_AUIPC: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        imme       = XLEN'(signed'({instr[31:12], 12'b0}));
        rs1_used   = 1'b0;
      end
      default: c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with load-use bubble insertion and a saturating bubble counter.
// One cycle latency; output holds while out_ready is low, in_ready drops on backpressure or hazard.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_take,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_ctrl,
  output logic [3:0]       out_aluop,
  output logic [XLEN-1:0]  out_imme,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_take,
  output logic [CNT_W-1:0] stall_cnt
);
  import decode_stage_pkg::*;

  logic [7:0]      dec_ctrl;
  logic [3:0]      dec_aluop;
  logic [XLEN-1:0] dec_imme;
  logic            rs1_used;
  logic            rs2_used;
  ctrl_t           ctrl_q;
  logic            hazard;
  logic            adv;

  decode_ctrl #(.XLEN(XLEN)) u_decode_ctrl (
    .instr    (in_instr),
    .ctrl     (dec_ctrl),
    .aluop    (dec_aluop),
    .imme     (dec_imme),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign out_ctrl = ctrl_q;

  // The held load's result is not available yet, so a dependent consumer must wait one cycle.
  assign hazard = (HAZARD_EN != 0) && in_valid && out_valid && ctrl_q.memread && (out_rd != 5'd0)
                  && (((out_rd == in_instr[19:15]) && rs1_used)
                   || ((out_rd == in_instr[24:20]) && rs2_used));

  assign adv      = !out_valid || out_ready;
  assign in_ready = !rst && (flush || (adv && !hazard));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      out_aluop <= '0;
      out_imme  <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_rd    <= '0;
      out_pc    <= '0;
      out_take  <= 1'b0;
      stall_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      if (hazard) begin
        out_valid <= 1'b0;
        if (stall_cnt != {CNT_W{1'b1}})
          stall_cnt <= stall_cnt + 1'b1;
      end else if (in_valid) begin
        out_valid <= 1'b1;
        ctrl_q    <= dec_ctrl;
        out_aluop <= dec_aluop;
        out_imme  <= dec_imme;
        out_rs1   <= in_instr[19:15];
        out_rs2   <= in_instr[24:20];
        out_rd    <= in_instr[11:7];
        out_pc    <= in_pc;
        out_take  <= in_take;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
